// File: rtl/mc_control_pkg.sv
// mips_pkg: opcode/funct codes, controller state encodings and ALU control codes for mc_control
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: instruction fields, ALU/memory status and all controller outputs
interface mc_control_if #(parameter int STATEW = 4);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic memready;
  logic pcen;
  logic iord;
  logic memread;
  logic memwrite;
  logic irwrite;
  logic memtoreg;
  logic regdst;
  logic regwrite;
  logic alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] aluctl;
  logic illegal_op;
  logic [STATEW-1:0] state;
  modport master (
    input opcode, funct, zero, memready,
    output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
    output alusrca, alusrcb, pcsrc, aluctl, illegal_op, state
  );
  modport slave (
    output opcode, funct, zero, memready,
    input pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
    input alusrca, alusrcb, pcsrc, aluctl, illegal_op, state
  );
endinterface

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: maps controller aluop plus R-type funct to the 3-bit ALU control code
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] aluctl
);
  logic [2:0] fn_ctl;
  // funct table; unknown functs fall back to add
  always_comb begin
    fn_ctl = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR : ALU_ADD;
    aluctl = aluop == ALUOP_SUB ? ALU_SUB : aluop == ALUOP_FUNCT ? fn_ctl : ALU_ADD;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main controller (Moore FSM); MC_CTRL_ADDI_EN adds the addi states
module mc_control
  import mips_pkg::*;
#(
  parameter int STATEW       = 4,
  parameter bit HAS_MEMREADY = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mc_control_if.master bus
);
  localparam logic [STATEW-1:0] FETCH  = STATEW'(S_FETCH);
  localparam logic [STATEW-1:0] DECODE = STATEW'(S_DECODE);
  localparam logic [STATEW-1:0] MEMADR = STATEW'(S_MEMADR);
  localparam logic [STATEW-1:0] MEMRD  = STATEW'(S_MEMRD);
  localparam logic [STATEW-1:0] MEMWB  = STATEW'(S_MEMWB);
  localparam logic [STATEW-1:0] MEMWR  = STATEW'(S_MEMWR);
  localparam logic [STATEW-1:0] EXEC   = STATEW'(S_EXEC);
  localparam logic [STATEW-1:0] ALUWB  = STATEW'(S_ALUWB);
  localparam logic [STATEW-1:0] BRANCH = STATEW'(S_BRANCH);
  localparam logic [STATEW-1:0] JUMP   = STATEW'(S_JUMP);
`ifdef MC_CTRL_ADDI_EN
  localparam logic [STATEW-1:0] ADDIEX = STATEW'(S_ADDIEX);
  localparam logic [STATEW-1:0] ADDIWB = STATEW'(S_ADDIWB);
`endif
  logic [STATEW-1:0] state_q, state_d, dec_next;
  logic mr, pcwrite, pcwritecond;
  aluop_t aluop;
  assign mr = HAS_MEMREADY ? bus.memready : 1'b1;
  // decode target by opcode; FETCH here means the opcode is unsupported
  always_comb begin
    dec_next = bus.opcode == OP_RTYPE ? EXEC :
               (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
               bus.opcode == OP_BEQ ? BRANCH :
               bus.opcode == OP_J ? JUMP : FETCH;
`ifdef MC_CTRL_ADDI_EN
    if (bus.opcode == OP_ADDI) dec_next = ADDIEX;
`endif
  end
  // next-state logic; memory states wait on memready, unknown encodings recover to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = mr ? DECODE : FETCH;
      DECODE: state_d = dec_next;
      MEMADR: state_d = bus.opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:  state_d = mr ? MEMWB : MEMRD;
      MEMWR:  state_d = mr ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
`ifdef MC_CTRL_ADDI_EN
      ADDIEX: state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
  end
  // state register, async reset back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  end
  // Moore output decode; everything held at 0 (aluctl=add) while reset is asserted
  always_comb begin
    bus.iord = 1'b0;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca = 1'b0;
    bus.alusrcb = 2'b00;
    bus.pcsrc = 2'b00;
    bus.illegal_op = 1'b0;
    pcwrite = 1'b0;
    pcwritecond = 1'b0;
    aluop = ALUOP_ADD;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          bus.memread = 1'b1;
          bus.alusrcb = 2'b01;
          bus.irwrite = mr;
          pcwrite = mr;
        end
        DECODE: begin
          bus.alusrcb = 2'b11;
          bus.illegal_op = dec_next == FETCH;
        end
        MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        MEMRD: begin
          bus.iord = 1'b1;
          bus.memread = 1'b1;
        end
        MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        MEMWR: begin
          bus.iord = 1'b1;
          bus.memwrite = 1'b1;
        end
        EXEC: begin
          bus.alusrca = 1'b1;
          aluop = ALUOP_FUNCT;
        end
        ALUWB: begin
          bus.regwrite = 1'b1;
          bus.regdst = 1'b1;
        end
        BRANCH: begin
          bus.alusrca = 1'b1;
          bus.pcsrc = 2'b01;
          pcwritecond = 1'b1;
          aluop = ALUOP_SUB;
        end
        JUMP: begin
          bus.pcsrc = 2'b10;
          pcwrite = 1'b1;
        end
`ifdef MC_CTRL_ADDI_EN
        ADDIEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        ADDIWB: bus.regwrite = 1'b1;
`endif
        default: ;
      endcase
    end
    bus.pcen = pcwrite | (pcwritecond & bus.zero);
  end
  assign bus.state = state_q;
  alu_decoder u_alu_dec (
    .aluop (aluop),
    .funct (bus.funct),
    .aluctl(bus.aluctl)
  );
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed vector table plus multi-cycle wait sequence for mc_control
module tb_mc_control;
  import mips_pkg::*;
  typedef struct {
    logic rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    logic mr;
    logic [3:0] st;
    logic [16:0] ctl;
  } vec_t;
  // ctl layout: pcen iord memread memwrite irwrite memtoreg regdst regwrite alusrca alusrcb pcsrc aluctl illegal_op
  localparam logic [16:0] C_RST   = 17'b0_0_0_0_0_0_0_0_0_00_00_010_0;
  localparam logic [16:0] C_FETCH = 17'b1_0_1_0_1_0_0_0_0_01_00_010_0;
  localparam logic [16:0] C_FWAIT = 17'b0_0_1_0_0_0_0_0_0_01_00_010_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [16:0] C_DECIL = 17'b0_0_0_0_0_0_0_0_0_11_00_010_1;
  localparam logic [16:0] C_MADR  = 17'b0_0_0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [16:0] C_MRD   = 17'b0_1_1_0_0_0_0_0_0_00_00_010_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_1_0_1_0_00_00_010_0;
  localparam logic [16:0] C_MWR   = 17'b0_1_0_1_0_0_0_0_0_00_00_010_0;
  localparam logic [16:0] C_EXOR  = 17'b0_0_0_0_0_0_0_0_1_00_00_001_0;
  localparam logic [16:0] C_EXADD = 17'b0_0_0_0_0_0_0_0_1_00_00_010_0;
  localparam logic [16:0] C_EXSUB = 17'b0_0_0_0_0_0_0_0_1_00_00_110_0;
  localparam logic [16:0] C_EXAND = 17'b0_0_0_0_0_0_0_0_1_00_00_000_0;
  localparam logic [16:0] C_AWB   = 17'b0_0_0_0_0_0_1_1_0_00_00_010_0;
  localparam logic [16:0] C_BRT   = 17'b1_0_0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [16:0] C_BRF   = 17'b0_0_0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [16:0] C_JMP   = 17'b1_0_0_0_0_0_0_0_0_00_10_010_0;
  localparam logic [16:0] C_AIWB  = 17'b0_0_0_0_0_0_0_1_0_00_00_010_0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [16:0] act;
  int checks = 0;
  int errors = 0;
  vec_t vq[$];
  mc_control_if #(.STATEW(4)) bus ();
  mc_control #(.STATEW(4), .HAS_MEMREADY(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );
  always #5 clk = ~clk;
  assign act = {bus.pcen, bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluctl, bus.illegal_op};
  function automatic void add(logic r, logic [5:0] op, logic [5:0] fn, logic z, logic mr, logic [3:0] st,
                              logic [16:0] ctl);
    vec_t v;
    v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl;
    vq.push_back(v);
  endfunction
  initial begin
    int mrd_waits, irw, rgw, done_cyc;
    bus.opcode = OP_LW; bus.funct = 6'd0; bus.zero = 1'b0; bus.memready = 1'b1;
    add(0, OP_LW, 0, 0, 1, S_FETCH, C_RST);
    add(0, OP_LW, 0, 0, 1, S_FETCH, C_RST);
    add(1, OP_LW, 0, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_LW, 0, 0, 1, S_DECODE, C_DEC);
    add(1, OP_LW, 0, 0, 1, S_MEMADR, C_MADR);
    add(1, OP_LW, 0, 0, 1, S_MEMRD, C_MRD);
    add(1, OP_LW, 0, 0, 1, S_MEMWB, C_MWB);
    add(1, OP_SW, 0, 0, 0, S_FETCH, C_FWAIT);
    add(1, OP_SW, 0, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_SW, 0, 0, 1, S_DECODE, C_DEC);
    add(1, OP_SW, 0, 0, 1, S_MEMADR, C_MADR);
    for (int i = 0; i < 3; i++) add(1, OP_SW, 0, 0, 0, S_MEMWR, C_MWR);
    add(1, OP_SW, 0, 0, 1, S_MEMWR, C_MWR);
    add(1, OP_BEQ, 0, 1, 1, S_FETCH, C_FETCH);
    add(1, OP_BEQ, 0, 1, 1, S_DECODE, C_DEC);
    add(1, OP_BEQ, 0, 1, 1, S_BRANCH, C_BRT);
    add(1, OP_BEQ, 0, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_BEQ, 0, 0, 1, S_DECODE, C_DEC);
    add(1, OP_BEQ, 0, 0, 1, S_BRANCH, C_BRF);
    add(1, OP_RTYPE, FN_OR, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_RTYPE, FN_OR, 0, 1, S_DECODE, C_DEC);
    add(1, OP_RTYPE, FN_OR, 0, 1, S_EXEC, C_EXOR);
    add(1, OP_RTYPE, FN_OR, 0, 1, S_ALUWB, C_AWB);
    add(1, OP_RTYPE, 6'b111111, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_RTYPE, 6'b111111, 0, 1, S_DECODE, C_DEC);
    add(1, OP_RTYPE, 6'b111111, 0, 1, S_EXEC, C_EXADD);
    add(1, OP_RTYPE, 6'b111111, 0, 1, S_ALUWB, C_AWB);
    add(1, OP_RTYPE, FN_SUB, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_RTYPE, FN_SUB, 0, 1, S_DECODE, C_DEC);
    add(1, OP_RTYPE, FN_SUB, 0, 1, S_EXEC, C_EXSUB);
    add(1, OP_RTYPE, FN_AND, 0, 1, S_ALUWB, C_AWB);
    add(1, OP_RTYPE, FN_AND, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_RTYPE, FN_AND, 0, 1, S_DECODE, C_DEC);
    add(1, OP_RTYPE, FN_AND, 0, 1, S_EXEC, C_EXAND);
    add(1, OP_RTYPE, FN_AND, 0, 1, S_ALUWB, C_AWB);
    add(1, OP_J, 0, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_J, 0, 0, 1, S_DECODE, C_DEC);
    add(1, OP_J, 0, 0, 1, S_JUMP, C_JMP);
    add(1, OP_ADDI, 0, 0, 1, S_FETCH, C_FETCH);
`ifdef MC_CTRL_ADDI_EN
    add(1, OP_ADDI, 0, 0, 1, S_DECODE, C_DEC);
    add(1, OP_ADDI, 0, 0, 1, S_ADDIEX, C_MADR);
    add(1, OP_ADDI, 0, 0, 1, S_ADDIWB, C_AIWB);
`else
    add(1, OP_ADDI, 0, 0, 1, S_DECODE, C_DECIL);
`endif
    add(1, OP_LW, 0, 0, 1, S_FETCH, C_FETCH);
    add(1, OP_LW, 0, 0, 1, S_DECODE, C_DEC);
    add(1, OP_LW, 0, 0, 1, S_MEMADR, C_MADR);
    add(0, OP_LW, 0, 0, 1, S_FETCH, C_RST);
    add(0, OP_LW, 0, 0, 1, S_FETCH, C_RST);
    add(1, OP_LW, 0, 0, 1, S_FETCH, C_FETCH);
    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n;
      bus.opcode = vq[i].op; bus.funct = vq[i].fn; bus.zero = vq[i].z; bus.memready = vq[i].mr;
      #1;
      checks++;
      if (bus.state !== vq[i].st) begin
        errors++;
        $display("FAIL vec%0d state: got %0d expected %0d", i, bus.state, vq[i].st);
      end
      checks++;
      if (act !== vq[i].ctl) begin
        errors++;
        $display("FAIL vec%0d ctl: got %b expected %b", i, act, vq[i].ctl);
      end
    end
    // lw with two FETCH waits and two MEMRD waits: expect 9 cycles, one irwrite, one regwrite
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mrd_waits = 0; irw = 0; rgw = 0; done_cyc = -1;
    for (int c = 0; c < 50 && done_cyc < 0; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      bus.opcode = OP_LW;
      bus.memready = !(c < 2 || (bus.state == S_MEMRD && mrd_waits < 2));
      #1;
      if (bus.state == S_MEMRD && !bus.memready) begin
        mrd_waits++;
        checks++;
        if (!(bus.memread && bus.iord && !bus.regwrite)) begin
          errors++;
          $display("FAIL memrd_hold: got memread=%b iord=%b regwrite=%b required 1 1 0", bus.memread, bus.iord,
                   bus.regwrite);
        end
      end
      irw += int'(bus.irwrite);
      rgw += int'(bus.regwrite);
      if (bus.state == S_MEMWB) done_cyc = c + 1;
    end
    checks++;
    if (done_cyc != 9) begin
      errors++;
      $display("FAIL lw_wait_latency: got %0d cycles required 9", done_cyc);
    end
    checks++;
    if (irw != 1 || rgw != 1) begin
      errors++;
      $display("FAIL lw_wait_pulses: got irwrite=%0d regwrite=%0d required 1 1", irw, rgw);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
